// File: rtl/sodor5_feed_pkg.sv
// Shared constants and state encoding for the sodor5 instruction-feed sequencer.
package sodor5_feed_pkg;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/feed_prog_mem.sv
// Program word storage: synchronous write, asynchronous read, no reset so
// contents survive a sequencer reset.
module feed_prog_mem #(
    parameter int DEPTH = sodor5_feed_pkg::DEPTH,
    parameter int AW    = 4,
    parameter int XLEN  = sodor5_feed_pkg::XLEN
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_feed_sequencer.sv
// Issues a stored program to the core under a stall handshake, once or looping,
// then flushes the pipeline with NOPs and reports completion.
module imem_feed_sequencer
    import sodor5_feed_pkg::*;
#(
    parameter int              DEPTH      = sodor5_feed_pkg::DEPTH,
    parameter int              AW         = 4,
    parameter int              XLEN       = sodor5_feed_pkg::XLEN,
    parameter int              DRAIN_NOPS = 5,
    parameter logic [XLEN-1:0] NOP_INSTR  = sodor5_feed_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_data,
    input  logic [AW:0]     prog_len,
    input  logic            loop_en,
    input  logic            start,
    input  logic            halt,
    input  logic            core_ready,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [AW-1:0]   pc_idx,
    output logic            busy,
    output logic            done,
    output logic [15:0]     issued_cnt
);

    localparam int            DW         = $clog2(DRAIN_NOPS + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_NOPS);

    feed_state_t     state_reg;
    logic [AW-1:0]   pc_idx_reg;
    logic [AW:0]     len_reg;
    logic            loop_reg;
    logic [DW-1:0]   drain_cnt_reg;
    logic [XLEN-1:0] instr_reg;
    logic            instr_valid_reg;
    logic [15:0]     issued_cnt_reg;

    logic [XLEN-1:0] mem_rdata;
    logic            mem_we;
    logic            last_word;
    logic            load_window;

    // Program may only be rewritten while nothing is being issued from it.
    assign load_window = (state_reg == IDLE) || (state_reg == DONE);
    assign mem_we      = load_en && load_window;
    assign last_word   = (({1'b0, pc_idx_reg} + (AW+1)'(1)) == len_reg);

    feed_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .XLEN  (XLEN)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_idx_reg),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            pc_idx_reg      <= '0;
            len_reg         <= '0;
            loop_reg        <= 1'b0;
            drain_cnt_reg   <= '0;
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
            issued_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        len_reg         <= prog_len;
                        loop_reg        <= loop_en;
                        pc_idx_reg      <= '0;
                        issued_cnt_reg  <= '0;
                        drain_cnt_reg   <= '0;
                        instr_reg       <= NOP_INSTR;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= (prog_len == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    // halt wins over core_ready: no program word leaves on this edge
                    if (halt) begin
                        instr_reg       <= NOP_INSTR;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= DRAIN;
                    end else if (core_ready) begin
                        instr_reg       <= mem_rdata;
                        instr_valid_reg <= 1'b1;
                        if (issued_cnt_reg != 16'hFFFF) begin
                            issued_cnt_reg <= issued_cnt_reg + 16'd1;
                        end
                        if (last_word) begin
                            if (loop_reg) begin
                                pc_idx_reg <= '0;
                            end else begin
                                state_reg <= DRAIN;
                            end
                        end else begin
                            pc_idx_reg <= pc_idx_reg + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The final NOP is held until the core takes it, then we retire.
                    if (core_ready) begin
                        instr_reg <= NOP_INSTR;
                        if (drain_cnt_reg == DRAIN_LAST) begin
                            instr_valid_reg <= 1'b0;
                            state_reg       <= DONE;
                        end else begin
                            instr_valid_reg <= 1'b1;
                            drain_cnt_reg   <= drain_cnt_reg + DW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign pc_idx      = pc_idx_reg;
    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign done        = (state_reg == DONE);
    assign issued_cnt  = issued_cnt_reg;

endmodule

// File: tb/tb_imem_feed_sequencer.sv
// Directed scoreboard bench for imem_feed_sequencer.
module tb_imem_feed_sequencer;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] NEW0 = 32'h00100093;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  prog_len;
    logic        loop_en;
    logic        start;
    logic        halt;
    logic        core_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  pc_idx;
    logic        busy;
    logic        done;
    logic [15:0] issued_cnt;

    int errors = 0;
    int checks = 0;
    int lat;
    int n;
    logic [31:0] exp_q[$];
    logic [31:0] prog [4];

    imem_feed_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .loop_en     (loop_en),
        .start       (start),
        .halt        (halt),
        .core_ready  (core_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_idx      (pc_idx),
        .busy        (busy),
        .done        (done),
        .issued_cnt  (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven, outputs sampled on the falling edge.
    // A valid word shown after an edge where core_ready was high is a new issue.
    task automatic tick();
        logic r;
        r = core_ready;
        @(posedge clk);
        @(negedge clk);
        if (instr_valid && r) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_issue", instr, 32'hxxxxxxxx);
            end else begin
                check("sb_instr", instr, exp_q.pop_front());
            end
            $display("issue instr=%h pc_idx=%0d issued_cnt=%0d", instr, pc_idx, issued_cnt);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] len, input logic lp);
        prog_len = len;
        loop_en  = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 60) begin
            tick();
            cnt++;
        end
        check("done_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic push_nops();
        for (int i = 0; i < 5; i++) exp_q.push_back(NOP);
    endtask

    initial begin
        prog[0] = 32'h19810113;
        prog[1] = 32'h3FE08013;
        prog[2] = 32'h0C900013;
        prog[3] = 32'h0EB10093;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; loop_en = 1'b0; start = 1'b0; halt = 1'b0; core_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_pc_idx", {28'b0, pc_idx}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_issued", {16'b0, issued_cnt}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) load_word(i[3:0], prog[i]);

        // Single pass, no stalls, plus a write attempt while running
        core_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(prog[i]);
        push_nops();
        start_run(5'd4, 1'b0);
        check("t1_valid_after_e0", {31'b0, instr_valid}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t1_word0_at_e1", instr, prog[0]);
        load_en = 1'b1; load_addr = 4'd1; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        wait_done(n);
        lat = 3 + n;
        check("t1_latency", lat, 32'd11);
        check("t1_issued", {16'b0, issued_cnt}, 32'd4);
        check("t1_valid_done", {31'b0, instr_valid}, 32'd0);
        check("t1_sb_left", exp_q.size(), 32'd0);

        // Stall of three cycles after word 1; word 1 must still be the original
        for (int i = 0; i < 4; i++) exp_q.push_back(prog[i]);
        push_nops();
        start_run(5'd4, 1'b0);
        tick();
        tick();
        check("t2_word1", instr, prog[1]);
        core_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_instr", instr, prog[1]);
            check("t2_hold_pc", {28'b0, pc_idx}, 32'd2);
            check("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
        end
        core_ready = 1'b1;
        wait_done(n);
        check("t2_issued", {16'b0, issued_cnt}, 32'd4);
        check("t2_sb_left", exp_q.size(), 32'd0);

        // Looping run of ten words, then halt
        for (int i = 0; i < 10; i++) exp_q.push_back(prog[i % 4]);
        push_nops();
        start_run(5'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_no_gap", {31'b0, instr_valid}, 32'd1);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("t3_halt_bubble", {31'b0, instr_valid}, 32'd0);
        check("t3_busy_drain", {31'b0, busy}, 32'd1);
        wait_done(n);
        check("t3_issued", {16'b0, issued_cnt}, 32'd10);
        check("t3_sb_left", exp_q.size(), 32'd0);

        // Empty program: drain only
        push_nops();
        start_run(5'd0, 1'b0);
        check("t4_busy", {31'b0, busy}, 32'd1);
        check("t4_valid", {31'b0, instr_valid}, 32'd0);
        wait_done(n);
        lat = 1 + n;
        check("t4_latency", lat, 32'd7);
        check("t4_issued", {16'b0, issued_cnt}, 32'd0);
        check("t4_sb_left", exp_q.size(), 32'd0);

        // Halt on the edge that would issue the last word
        exp_q.push_back(prog[0]);
        push_nops();
        start_run(5'd2, 1'b0);
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("t5_halt_last_valid", {31'b0, instr_valid}, 32'd0);
        wait_done(n);
        check("t5_issued", {16'b0, issued_cnt}, 32'd1);
        check("t5_sb_left", exp_q.size(), 32'd0);

        // Load and start on the same edge: new data is issued
        exp_q.push_back(NEW0);
        push_nops();
        load_en = 1'b1; load_addr = 4'd0; load_data = NEW0;
        start_run(5'd1, 1'b0);
        load_en = 1'b0;
        wait_done(n);
        check("t6_issued", {16'b0, issued_cnt}, 32'd1);
        check("t6_sb_left", exp_q.size(), 32'd0);
        load_word(4'd0, prog[0]);

        // Asynchronous reset while word 2 is on the bus
        for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
        start_run(5'd4, 1'b0);
        tick();
        tick();
        tick();
        check("t7_word2", instr, prog[2]);
        #2 reset = 1'b0;
        #1;
        check("t7_async_instr", instr, NOP);
        check("t7_async_valid", {31'b0, instr_valid}, 32'd0);
        check("t7_async_busy", {31'b0, busy}, 32'd0);
        check("t7_async_done", {31'b0, done}, 32'd0);
        check("t7_sb_left_before", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(prog[i]);
        push_nops();
        start_run(5'd4, 1'b0);
        wait_done(n);
        check("t7_issued", {16'b0, issued_cnt}, 32'd4);
        check("t7_sb_left", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
